// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - collective (SCAN) elevator car sequencer
// Optional feature macro: ELEV_DOOR_HOLD_EN adds the door_hold input that
// keeps the door open while asserted.
module elevator_call_scheduler #(
  parameter int FLOORS     = 4,
  parameter int FLOOR_BITS = 2,
  parameter int MOVE_TICKS = 8,
  parameter int DOOR_TICKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  input  logic [FLOORS-1:0]     call_req,
  output logic [FLOOR_BITS-1:0] cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [FLOORS-1:0]     pending,
  output logic                  arrive
);

  localparam int CNT_MAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]      MOVE_LAST = CNT_W'(MOVE_TICKS - 1);
  localparam logic [CNT_W-1:0]      DOOR_LAST = CNT_W'(DOOR_TICKS - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [FLOOR_BITS-1:0] FLOOR_ONE = FLOOR_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVING = 2'd1,
    S_DOOR   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  check_q, check_d;
  logic [FLOOR_BITS-1:0] floor_d;
  logic                  dir_d;
  logic [FLOORS-1:0]     pend_d;
  logic                  arrive_d;

  logic [FLOORS-1:0]     pend_nx;
  logic [FLOORS-1:0]     pend_eval;
  logic [FLOORS-1:0]     cur_mask;
  logic                  above, below, here;
  logic                  go_up, go_down;
  logic                  restart;
  logic                  hold;

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  // State and datapath registers; async reset parks the car at floor 0, idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      check_q   <= 1'b0;
      cur_floor <= '0;
      dir_up    <= 1'b0;
      pending   <= '0;
      arrive    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      check_q   <= check_d;
      cur_floor <= floor_d;
      dir_up    <= dir_d;
      pending   <= pend_d;
      arrive    <= arrive_d;
    end
  end

  // Next-state logic: SCAN decisions on the merged call vector, tick counting
  always_comb begin
    pend_nx  = pending | call_req;
    cur_mask = '0;
    cur_mask[cur_floor] = 1'b1;
    // While the door is open, a call at this floor only extends the dwell
    restart   = (state_q == S_DOOR) && call_req[cur_floor];
    pend_eval = (state_q == S_DOOR) ? (pend_nx & ~cur_mask) : pend_nx;

    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pend_eval[i] && (i > int'(cur_floor))) above = 1'b1;
      if (pend_eval[i] && (i < int'(cur_floor))) below = 1'b1;
    end
    here    = |(pend_eval & cur_mask);
    // Keep heading the same way while calls remain ahead
    go_up   = above && (dir_up || !below);
    go_down = !go_up && below;

    state_d  = state_q;
    cnt_d    = cnt_q;
    check_d  = 1'b0;
    floor_d  = cur_floor;
    dir_d    = dir_up;
    pend_d   = pend_eval;
    arrive_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (here) begin
          state_d  = S_DOOR;
          pend_d   = pend_eval & ~cur_mask;
          arrive_d = 1'b1;
        end else if (go_up) begin
          dir_d   = 1'b1;
          state_d = S_MOVING;
        end else if (go_down) begin
          dir_d   = 1'b0;
          state_d = S_MOVING;
        end
      end
      S_MOVING: begin
        if (check_q) begin
          // First cycle at a new floor: stop if it is wanted, else travel on
          cnt_d = '0;
          if (here) begin
            state_d  = S_DOOR;
            pend_d   = pend_eval & ~cur_mask;
            arrive_d = 1'b1;
          end
        end else if (tick) begin
          if (cnt_q == MOVE_LAST) begin
            cnt_d   = '0;
            check_d = 1'b1;
            floor_d = dir_up ? (cur_floor + FLOOR_ONE) : (cur_floor - FLOOR_ONE);
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_DOOR: begin
        if (restart || hold) begin
          cnt_d = '0;
        end else if (tick) begin
          if (cnt_q == DOOR_LAST) begin
            cnt_d = '0;
            if (go_up) begin
              dir_d   = 1'b1;
              state_d = S_MOVING;
            end else if (go_down) begin
              dir_d   = 1'b0;
              state_d = S_MOVING;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs decoded from the registered state
  always_comb begin
    moving    = (state_q == S_MOVING);
    door_open = (state_q == S_DOOR);
  end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Sequences the elevator car for the elevator core. Latches floor call requests from the debounced switch inputs and chooses travel direction with a collective (SCAN) policy. Steps the car one floor per move period and times the door-open dwell. Its outputs drive the floor indicator, LEDs and VGA car position inside the elevator datapath.

Parameters:
FLOORS, 4, number of floors (>=2); floor 0 is the bottom floor.
FLOOR_BITS, 2, width of the floor index; must satisfy 2^FLOOR_BITS >= FLOORS.
MOVE_TICKS, 8, tick strobes needed to travel one floor (>=1).
DOOR_TICKS, 4, tick strobes the door stays open (>=1).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  one-cycle timebase strobe from the prescaler
call_req  input  FLOORS  one-cycle call pulses, one bit per floor
cur_floor  output  FLOOR_BITS  current car floor
dir_up  output  1  1 = up, 0 = down; last chosen direction
moving  output  1  car travelling between floors
door_open  output  1  door open at cur_floor
pending  output  FLOORS  latched, unserved calls
arrive  output  1  one-cycle pulse when the car stops at a floor

Behaviour:
- Reset (async, rst_n=0) forces all outputs to 0: cur_floor=0, dir_up=0, moving=0, door_open=0, pending=0, arrive=0. It also forces state IDLE and clears the tick counter, including mid-move and mid-door.
- pend_nx = pending | call_req. All decisions in a cycle use pend_nx. A call is never lost, even when it coincides with tick or with a state change.
- above = any pend_nx bit with index > cur_floor. below = any bit with index < cur_floor. here = pend_nx[cur_floor].
- States: IDLE, MOVING, DOOR_OPEN. Registered outputs follow the state: moving=(MOVING), door_open=(DOOR_OPEN).
- IDLE:
  - here → DOOR_OPEN next cycle; clear pending[cur_floor]; arrive=1.
  - else above && (dir_up || !below) → dir_up=1, MOVING.
  - else below → dir_up=0, MOVING.
  - else stay in IDLE.
- MOVING:
  - The tick counter clears on state entry and increments on each tick.
  - On the tick that reaches MOVE_TICKS, cur_floor ±1 according to dir_up.
  - The arrival check runs the following cycle, at the new floor. If here → DOOR_OPEN; clear bit; arrive=1. Otherwise restart the counter and keep moving in dir_up.
  - Calls at the floor the car just left while MOVING are latched and served later.
- DOOR_OPEN:
  - The counter clears on entry and counts ticks.
  - A call_req for cur_floor restarts the dwell counter and is not latched.
  - When the count reaches DOOR_TICKS, re-evaluate with the IDLE rules and go to MOVING or IDLE. Keep dir_up if calls remain ahead, reverse it only if calls exist solely behind.
- cur_floor never leaves 0..FLOORS-1. The car moves only toward a pending bit, and bits clear only on arrival.
- Latency: idle call to a different floor gives moving=1 one cycle after the call_req pulse. Call at the current floor while idle gives door_open=1 one cycle after the pulse.
- arrive is high for exactly one clk cycle, in the same cycle door_open rises.

Optional Feature:
ELEV_DOOR_HOLD_EN
- Defined: adds input port door_hold (1 bit). While door_hold=1 in DOOR_OPEN, the dwell counter is held at 0, so the door stays open. Once door_hold drops, the door closes DOOR_TICKS ticks later. door_hold has no effect in other states.
- Undefined: the port is absent and the dwell is always exactly DOOR_TICKS ticks.

Test Plan:
(FLOORS=4, MOVE_TICKS=3, DOOR_TICKS=2, tick every cycle)
1. After reset, call_req=4'b1000 for one cycle → moving=1 next cycle, dir_up=1. cur_floor steps 1,2,3 at 3-tick intervals. Then arrive pulse, door_open=1 for 2 ticks, pending=0, back to IDLE, moving=0.
2. Idle at floor 0, call_req=4'b0001 → door_open=1 next cycle, arrive=1 for one cycle, pending stays 4'b0000.
3. Car moving up from 0 toward floor 3; at cur_floor=1 pulse 4'b0100, then 4'b0001 → stops at 2, then at 3, then reverses (dir_up=0) and stops at 0. pending returns to 0.
4. Car in DOOR_OPEN at floor 2, after 1 tick pulse call_req=4'b0100 → door_open lasts 2 further ticks and pending[2] stays 0.
5. Reset asserted mid-move at cur_floor=2 → all outputs are 0 in the same cycle, without waiting for a clk edge. After release, a new call behaves as in scenario 1.
6. With ELEV_DOOR_HOLD_EN, door_hold=1 for 10 cycles during DOOR_OPEN → door_open stays 1 throughout, then closes 2 ticks after door_hold falls.
